lsu_ctrl: RTL and testbench

Load/store sequencer for the light core: accepts one memory request per transaction from the execute stage, checks alignment, drives the single-port data-memory bus, and returns load data already extracted and sign- or zero-extended. It sits between the core control FSM and data memory. It owns byte-lane placement for stores and lane extraction for loads, so the datapath only ever sees 32-bit register values.

---
 rtl/lsu_pkg.sv | 75 +++++++
 rtl/lsu_ctrl_if.sv | 33 +++
 rtl/lsu_ldext.sv | 38 +++
 rtl/lsu_ctrl.sv | 179 +++++++++++++++++
 tb/tb_lsu_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store sequencer.
//   - lsu_state_e  : sequencer states (IDLE, ACCESS, RESP)
//   - F3_*         : access-type encodings (IR[14:12])
//   - ERR_*        : error-cause codes reported by req_check()
//   - req_check()  : legality check of a request (funct3 / alignment)
//   - place_store(): byte-lane placement of store data and byte enables
package lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_MISALIGN = 2'd1;
   localparam logic [1:0] ERR_FUNCT3   = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  be;
   } st_lane_t;

   // Unsigned variants only exist for loads, so a store with BU/HU is illegal.
   function automatic logic [1:0] req_check(input logic we, input logic [2:0] f3,
                                            input logic [1:0] off);
      logic [1:0] cause;
      cause = ERR_NONE;
      case (f3)
         F3_B:    cause = ERR_NONE;
         F3_H:    cause = off[0] ? ERR_MISALIGN : ERR_NONE;
         F3_W:    cause = (off != 2'b00) ? ERR_MISALIGN : ERR_NONE;
         F3_BU:   cause = we ? ERR_FUNCT3 : ERR_NONE;
         F3_HU:   cause = we ? ERR_FUNCT3 : (off[0] ? ERR_MISALIGN : ERR_NONE);
         default: cause = ERR_FUNCT3;
      endcase
      return cause;
   endfunction

   // Loads read the whole word; only stores get lane-placed data.
   function automatic st_lane_t place_store(input logic we, input logic [2:0] f3,
                                            input logic [1:0] off, input logic [31:0] wdata);
      st_lane_t lane;
      lane.data = 32'h0000_0000;
      lane.be   = 4'b1111;
      if (we) begin
         case (f3)
            F3_B: begin
               lane.data = {24'h00_0000, wdata[7:0]} << {off, 3'b000};
               lane.be   = 4'b0001 << off;
            end
            F3_H: begin
               lane.data = off[1] ? {wdata[15:0], 16'h0000} : {16'h0000, wdata[15:0]};
               lane.be   = off[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
               lane.data = wdata;
               lane.be   = 4'b1111;
            end
         endcase
      end else begin
         lane.data = 32'h0000_0000;
         lane.be   = 4'b1111;
      end
      return lane;
   endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: core request/response and data-memory bus signals of lsu_ctrl.
//   slave  modport : the sequencer (receives req_*, mem_ack/mem_rdata)
//   master modport : the core/memory side driving the sequencer
interface lsu_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
   );
endinterface

// File: rtl/lsu_ldext.sv
// lsu_ldext: combinational load-data extraction and sign/zero extension.
//   rdata  : raw 32-bit word from memory
//   funct3 : access type (B, H, W, BU, HU)
//   off    : byte offset addr[1:0]
//   data   : right-aligned, extended register value
module lsu_ldext
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   output logic [31:0] data
);
   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Lane select followed by extension according to the access type.
   always_comb begin
      byte_s = 8'h00;
      half_s = 16'h0000;
      data   = rdata;
      case (off)
         2'd0:    byte_s = rdata[7:0];
         2'd1:    byte_s = rdata[15:8];
         2'd2:    byte_s = rdata[23:16];
         2'd3:    byte_s = rdata[31:24];
         default: byte_s = rdata[7:0];
      endcase
      half_s = off[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         F3_B:    data = {{24{byte_s[7]}}, byte_s};
         F3_BU:   data = {24'h00_0000, byte_s};
         F3_H:    data = {{16{half_s[15]}}, half_s};
         F3_HU:   data = {16'h0000, half_s};
         default: data = rdata;
      endcase
   end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between the core and single-port data memory.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : lsu_ctrl_if.slave (req_* from core, rsp_* to core, mem_* to memory)
// Parameter TIMEOUT (1..1023): ACCESS cycles without mem_ack before abort.
// Optional feature macro LSU_TIMEOUT_EN enables the ACCESS timeout counter;
// without it ACCESS waits for mem_ack indefinitely.
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic     clock,
   input  logic     reset,
   lsu_ctrl_if.slave bus
);
   if (TIMEOUT < 1 || TIMEOUT > 1023) begin : g_bad_timeout
      $error("lsu_ctrl: TIMEOUT out of range 1..1023");
   end

   lsu_state_e  state_r, next_s;
   logic        hs_s, illegal_s, tmo_hit_s;
   logic [1:0]  cause_s;
   st_lane_t    lane_s;
   logic [31:0] ld_data_s;

   logic        mem_req_r, mem_we_r, rsp_valid_r, rsp_err_r;
   logic [31:0] mem_addr_r, mem_wdata_r, rsp_rdata_r;
   logic [3:0]  mem_be_r;
   logic [2:0]  funct3_r;
   logic [1:0]  off_r;

   logic        mem_req_s, mem_we_s, rsp_valid_s, rsp_err_s;
   logic [31:0] mem_addr_s, mem_wdata_s, rsp_rdata_s;
   logic [3:0]  mem_be_s;
   logic [2:0]  funct3_s;
   logic [1:0]  off_s;

   // Ready is forced low while reset is held, otherwise decoded from state.
   assign bus.req_ready = reset & (state_r == ST_IDLE);
   assign hs_s      = bus.req_valid & (state_r == ST_IDLE);
   assign cause_s   = req_check(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
   assign illegal_s = (cause_s != ERR_NONE);
   assign lane_s    = place_store(bus.req_we, bus.req_funct3, bus.req_addr[1:0], bus.req_wdata);

   lsu_ldext u_ldext (
      .rdata  (bus.mem_rdata),
      .funct3 (funct3_r),
      .off    (off_r),
      .data   (ld_data_s)
   );

`ifdef LSU_TIMEOUT_EN
   localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);
   logic [9:0] tmo_cnt_r;

   // Counts ACCESS cycles without ack; zero whenever outside ACCESS.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tmo_cnt_r <= 10'd0;
      end else if (state_r != ST_ACCESS) begin
         tmo_cnt_r <= 10'd0;
      end else if (!bus.mem_ack) begin
         tmo_cnt_r <= tmo_cnt_r + 10'd1;
      end else begin
         tmo_cnt_r <= tmo_cnt_r;
      end
   end

   // An ack in the final cycle takes priority over the timeout.
   assign tmo_hit_s = (state_r == ST_ACCESS) & ~bus.mem_ack & (tmo_cnt_r == TMO_LAST);
`else
   assign tmo_hit_s = 1'b0;
`endif

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // Next-state decode.
   always_comb begin
      next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (hs_s) begin
               next_s = illegal_s ? ST_RESP : ST_ACCESS;
            end else begin
               next_s = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (bus.mem_ack || tmo_hit_s) begin
               next_s = ST_RESP;
            end else begin
               next_s = ST_ACCESS;
            end
         end
         ST_RESP:  next_s = ST_IDLE;
         default:  next_s = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs; bus fields only change on a legal accept.
   always_comb begin
      mem_req_s   = (next_s == ST_ACCESS);
      rsp_valid_s = (next_s == ST_RESP);
      mem_we_s    = mem_we_r;
      mem_addr_s  = mem_addr_r;
      mem_wdata_s = mem_wdata_r;
      mem_be_s    = mem_be_r;
      funct3_s    = funct3_r;
      off_s       = off_r;
      rsp_err_s   = 1'b0;
      rsp_rdata_s = 32'h0000_0000;
      if (hs_s) begin
         if (illegal_s) begin
            rsp_err_s = 1'b1;
         end else begin
            mem_we_s    = bus.req_we;
            mem_addr_s  = {bus.req_addr[31:2], 2'b00};
            mem_wdata_s = lane_s.data;
            mem_be_s    = lane_s.be;
            funct3_s    = bus.req_funct3;
            off_s       = bus.req_addr[1:0];
         end
      end else if (state_r == ST_ACCESS) begin
         if (bus.mem_ack) begin
            rsp_rdata_s = mem_we_r ? 32'h0000_0000 : ld_data_s;
         end else if (tmo_hit_s) begin
            rsp_err_s = 1'b1;
         end else begin
            rsp_err_s = 1'b0;
         end
      end else begin
         rsp_err_s = 1'b0;
      end
   end

   // Output and request-context registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mem_req_r   <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= 32'h0000_0000;
         mem_wdata_r <= 32'h0000_0000;
         mem_be_r    <= 4'b0000;
         funct3_r    <= 3'b000;
         off_r       <= 2'b00;
         rsp_valid_r <= 1'b0;
         rsp_err_r   <= 1'b0;
         rsp_rdata_r <= 32'h0000_0000;
      end else begin
         mem_req_r   <= mem_req_s;
         mem_we_r    <= mem_we_s;
         mem_addr_r  <= mem_addr_s;
         mem_wdata_r <= mem_wdata_s;
         mem_be_r    <= mem_be_s;
         funct3_r    <= funct3_s;
         off_r       <= off_s;
         rsp_valid_r <= rsp_valid_s;
         rsp_err_r   <= rsp_err_s;
         rsp_rdata_r <= rsp_rdata_s;
      end
   end

   assign bus.mem_req   = mem_req_r;
   assign bus.mem_we    = mem_we_r;
   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_wdata = mem_wdata_r;
   assign bus.mem_be    = mem_be_r;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_err   = rsp_err_r;
   assign bus.rsp_rdata = rsp_rdata_r;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: table-driven bench for lsu_ctrl plus hand sequences for
// delayed ack, idle ack, reset mid-access and (with LSU_TIMEOUT_EN) timeout.
module tb_lsu_ctrl;
   logic clock;
   logic reset;
   int   total;
   int   bad;

   lsu_ctrl_if bus();

   lsu_ctrl #(.TIMEOUT(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
      logic [3:0]  exp_be;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata);
      @(posedge clock); #1;
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      @(posedge clock); #1;
      bus.req_valid  = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      bus.mem_rdata = v.rdata;
      drive_req(v.we, v.f3, v.addr, v.wdata);
      if (!v.err) begin
         bus.mem_ack = 1'b1;
         @(negedge clock);
         check($sformatf("v%0d_mem_req", idx), {31'd0, bus.mem_req}, 32'd1);
         check($sformatf("v%0d_mem_addr", idx), bus.mem_addr, v.exp_addr);
         check($sformatf("v%0d_mem_be", idx), {28'd0, bus.mem_be}, {28'd0, v.exp_be});
         check($sformatf("v%0d_mem_we", idx), {31'd0, bus.mem_we}, {31'd0, v.we});
         if (v.we) begin
            check($sformatf("v%0d_mem_wdata", idx), bus.mem_wdata, v.exp_wdata);
         end
         @(posedge clock); #1;
         bus.mem_ack = 1'b0;
      end
      @(negedge clock);
      check($sformatf("v%0d_rsp_valid", idx), {31'd0, bus.rsp_valid}, 32'd1);
      check($sformatf("v%0d_rsp_err", idx), {31'd0, bus.rsp_err}, {31'd0, v.err});
      check($sformatf("v%0d_rsp_rdata", idx), bus.rsp_rdata, v.exp_rdata);
      check($sformatf("v%0d_mem_req_off", idx), {31'd0, bus.mem_req}, 32'd0);
      @(negedge clock);
      check($sformatf("v%0d_rsp_pulse", idx), {31'd0, bus.rsp_valid}, 32'd0);
   endtask

   initial begin
      int tmo_high;
      int rsp_at;
      logic rsp_err_seen;
      total = 0;
      bad   = 0;
      reset = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      bus.mem_ack    = 1'b0;
      bus.mem_rdata  = 32'h0;

      //            we    f3      addr          wdata         rdata         err   exp_addr      exp_wdata     be       exp_rdata
      vecs[0]  = '{1'b0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_0000, 1'b0, 32'h0000_1000, 32'h0,        4'b1111, 32'hFFFF_FF80};
      vecs[1]  = '{1'b0, 3'b101, 32'h0000_2002, 32'h0,        32'h9ABC_1234, 1'b0, 32'h0000_2000, 32'h0,        4'b1111, 32'h0000_9ABC};
      vecs[2]  = '{1'b0, 3'b001, 32'h0000_2002, 32'h0,        32'h9ABC_1234, 1'b0, 32'h0000_2000, 32'h0,        4'b1111, 32'hFFFF_9ABC};
      vecs[3]  = '{1'b1, 3'b000, 32'h0000_3001, 32'h1234_56AB, 32'hFFFF_FFFF, 1'b0, 32'h0000_3000, 32'h0000_AB00, 4'b0010, 32'h0};
      vecs[4]  = '{1'b1, 3'b001, 32'h0000_3002, 32'h0000_CAFE, 32'hFFFF_FFFF, 1'b0, 32'h0000_3000, 32'hCAFE_0000, 4'b1100, 32'h0};
      vecs[5]  = '{1'b0, 3'b100, 32'h0000_1001, 32'h0,        32'h0000_F200, 1'b0, 32'h0000_1000, 32'h0,        4'b1111, 32'h0000_00F2};
      vecs[6]  = '{1'b1, 3'b010, 32'h0000_5000, 32'hA5A5_1234, 32'hFFFF_FFFF, 1'b0, 32'h0000_5000, 32'hA5A5_1234, 4'b1111, 32'h0};
      vecs[7]  = '{1'b0, 3'b010, 32'h0000_6004, 32'h0,        32'h1357_9BDF, 1'b0, 32'h0000_6004, 32'h0,        4'b1111, 32'h1357_9BDF};
      vecs[8]  = '{1'b0, 3'b001, 32'h0000_7000, 32'h0,        32'h0000_8001, 1'b0, 32'h0000_7000, 32'h0,        4'b1111, 32'hFFFF_8001};
      vecs[9]  = '{1'b0, 3'b010, 32'h0000_4002, 32'h0,        32'hFFFF_FFFF, 1'b1, 32'h0,        32'h0,        4'b0000, 32'h0};
      vecs[10] = '{1'b1, 3'b001, 32'h0000_4001, 32'h0000_1111, 32'hFFFF_FFFF, 1'b1, 32'h0,        32'h0,        4'b0000, 32'h0};
      vecs[11] = '{1'b0, 3'b011, 32'h0000_4000, 32'h0,        32'hFFFF_FFFF, 1'b1, 32'h0,        32'h0,        4'b0000, 32'h0};
      vecs[12] = '{1'b1, 3'b100, 32'h0000_4000, 32'h0000_0055, 32'hFFFF_FFFF, 1'b1, 32'h0,        32'h0,        4'b0000, 32'h0};
      vecs[13] = '{1'b0, 3'b110, 32'h0000_4000, 32'h0,        32'hFFFF_FFFF, 1'b1, 32'h0,        32'h0,        4'b0000, 32'h0};
      vecs[14] = '{1'b0, 3'b101, 32'h0000_4003, 32'h0,        32'hFFFF_FFFF, 1'b1, 32'h0,        32'h0,        4'b0000, 32'h0};

      // Reset state
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
      check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
      check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("rst_mem_addr", bus.mem_addr, 32'd0);
      check("rst_mem_be", {28'd0, bus.mem_be}, 32'd0);
      check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      reset = 1'b1;
      @(negedge clock);
      check("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);

      for (int i = 0; i < 15; i++) begin
         run_vec(vecs[i], i);
      end

      // Ack delayed three cycles: bus held stable, no response until ack
      bus.mem_rdata = 32'h0102_0304;
      drive_req(1'b0, 3'b010, 32'h0000_8004, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check($sformatf("dly%0d_mem_req", i), {31'd0, bus.mem_req}, 32'd1);
         check($sformatf("dly%0d_mem_addr", i), bus.mem_addr, 32'h0000_8004);
         check($sformatf("dly%0d_rsp_valid", i), {31'd0, bus.rsp_valid}, 32'd0);
         @(posedge clock); #1;
      end
      bus.mem_ack = 1'b1;
      @(posedge clock); #1;
      bus.mem_ack = 1'b0;
      @(negedge clock);
      check("dly_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("dly_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
      check("dly_rsp_rdata", bus.rsp_rdata, 32'h0102_0304);

      // Ack while idle is ignored
      @(posedge clock); #1;
      bus.mem_ack = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         check($sformatf("idleack%0d_rsp_valid", i), {31'd0, bus.rsp_valid}, 32'd0);
         check($sformatf("idleack%0d_mem_req", i), {31'd0, bus.mem_req}, 32'd0);
      end
      @(posedge clock); #1;
      bus.mem_ack = 1'b0;

`ifdef LSU_TIMEOUT_EN
      // Ack withheld: mem_req for exactly TIMEOUT cycles, then error response
      tmo_high     = 0;
      rsp_at       = -1;
      rsp_err_seen = 1'b0;
      drive_req(1'b0, 3'b010, 32'h0000_9000, 32'h0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (bus.mem_req) tmo_high = tmo_high + 1;
         if (bus.rsp_valid) begin
            rsp_at       = i;
            rsp_err_seen = bus.rsp_err;
         end
      end
      check("tmo_req_cycles", tmo_high, 32'd4);
      check("tmo_rsp_cycle", rsp_at, 32'd4);
      check("tmo_rsp_err", {31'd0, rsp_err_seen}, 32'd1);
`else
      // Ack withheld: ACCESS waits with mem_req high until ack arrives
      tmo_high     = 0;
      rsp_at       = -1;
      rsp_err_seen = 1'b0;
      bus.mem_rdata = 32'h0BAD_F00D;
      drive_req(1'b0, 3'b010, 32'h0000_9000, 32'h0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (bus.mem_req) tmo_high = tmo_high + 1;
         if (bus.rsp_valid) rsp_at = i;
      end
      check("wait_req_cycles", tmo_high, 32'd10);
      check("wait_no_rsp", rsp_at, -32'sd1);
      @(posedge clock); #1;
      bus.mem_ack = 1'b1;
      @(posedge clock); #1;
      bus.mem_ack = 1'b0;
      @(negedge clock);
      rsp_err_seen = bus.rsp_err;
      check("wait_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("wait_rsp_err", {31'd0, rsp_err_seen}, 32'd0);
      check("wait_rsp_rdata", bus.rsp_rdata, 32'h0BAD_F00D);
`endif
      // Late ack back in IDLE has no effect
      @(posedge clock); #1;
      bus.mem_ack = 1'b1;
      @(posedge clock); #1;
      bus.mem_ack = 1'b0;
      @(negedge clock);
      check("late_ack_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("late_ack_mem_req", {31'd0, bus.mem_req}, 32'd0);

      // Reset asserted in ACCESS: outputs drop at once, no response afterwards
      drive_req(1'b0, 3'b010, 32'h0000_A000, 32'h0);
      @(negedge clock);
      check("mid_mem_req_pre", {31'd0, bus.mem_req}, 32'd1);
      #1;
      reset = 1'b0;
      #1;
      check("mid_mem_req", {31'd0, bus.mem_req}, 32'd0);
      check("mid_mem_addr", bus.mem_addr, 32'd0);
      check("mid_req_ready", {31'd0, bus.req_ready}, 32'd0);
      check("mid_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      @(posedge clock); #1;
      bus.mem_ack = 1'b1;
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      bus.mem_ack = 1'b0;
      @(negedge clock);
      check("post_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("post_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

      // Fresh LW after reset
      vecs[0] = '{1'b0, 3'b010, 32'h0000_0000, 32'h0, 32'hDEAD_BEEF, 1'b0,
                  32'h0000_0000, 32'h0, 4'b1111, 32'hDEAD_BEEF};
      run_vec(vecs[0], 99);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
